// File: rtl/line_drawer_pkg.sv
// Shared screen geometry, coordinate widths and state encoding for the plotting pipeline
// (controller, line drawer, framebuffer writer).
package line_drawer_pkg;

    localparam int DEFAULT_HOR_ACTIVE_PIXELS = 640;
    localparam int DEFAULT_VER_ACTIVE_PIXELS = 480;
    localparam int X_WIDTH = $clog2(DEFAULT_HOR_ACTIVE_PIXELS);
    localparam int Y_WIDTH = $clog2(DEFAULT_VER_ACTIVE_PIXELS);

    // Two extra bits keep 2*err and -|dy| representable for any on-screen segment.
    function automatic int err_width(input int xw, input int yw);
        return ((xw > yw) ? xw : yw) + 2;
    endfunction

    localparam int ERR_WIDTH = err_width(X_WIDTH, Y_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PLOT  = 2'd2
    } state_t;

endpackage

// File: rtl/line_step.sv
// One Bresenham step: from the current pixel and error term, produce the next pixel and error.
module line_step #(
    parameter int XW = 10,
    parameter int YW = 9,
    parameter int EW = 12
) (
    input  logic signed [EW-1:0] err,
    input  logic signed [EW-1:0] dx,
    input  logic signed [EW-1:0] dy,
    input  logic                 sx_neg,
    input  logic                 sy_neg,
    input  logic [XW-1:0]        cur_x,
    input  logic [YW-1:0]        cur_y,
    output logic [XW-1:0]        next_x,
    output logic [YW-1:0]        next_y,
    output logic signed [EW-1:0] next_err
);

    logic signed [EW-1:0] e2;

    // Both axis decisions look at the same e2, so a diagonal move updates err twice.
    always_comb begin
        e2       = err <<< 1;
        next_err = err;
        next_x   = cur_x;
        next_y   = cur_y;
        if (e2 >= dy) begin
            next_err = next_err + dy;
            next_x   = sx_neg ? (cur_x - XW'(1)) : (cur_x + XW'(1));
        end
        if (e2 <= dx) begin
            next_err = next_err + dx;
            next_y   = sy_neg ? (cur_y - YW'(1)) : (cur_y + YW'(1));
        end
    end

endmodule

// File: rtl/line_drawer.sv
// Rasterises one segment between two inclusive endpoints into a valid/ready pixel stream,
// one pixel per accepted handshake, drawn from (x1,y1) toward (x2,y2).
module line_drawer
    import line_drawer_pkg::*;
#(
    parameter  int HOR_ACTIVE_PIXELS = DEFAULT_HOR_ACTIVE_PIXELS,
    parameter  int VER_ACTIVE_PIXELS = DEFAULT_VER_ACTIVE_PIXELS,
    localparam int XW = $clog2(HOR_ACTIVE_PIXELS),
    localparam int YW = $clog2(VER_ACTIVE_PIXELS),
    localparam int EW = err_width(XW, YW)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          ready,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y1,
    input  logic [XW-1:0] x2,
    input  logic [YW-1:0] y2,
    output logic [XW-1:0] pixel_x,
    output logic [YW-1:0] pixel_y,
    output logic          pixel_valid,
    input  logic          pixel_ready
);

    state_t state, state_next;

    logic [XW-1:0]        start_x, end_x, cur_x, step_x;
    logic [YW-1:0]        start_y, end_y, cur_y, step_y;
    logic signed [EW-1:0] dx, dy, err, step_err;
    logic signed [EW-1:0] setup_dx, abs_dy, setup_dy;
    logic                 sx_neg, sy_neg;
    logic                 at_end;

    function automatic logic [XW-1:0] clamp_x(input logic [XW-1:0] v);
        return (int'(v) >= HOR_ACTIVE_PIXELS) ? XW'(HOR_ACTIVE_PIXELS - 1) : v;
    endfunction

    function automatic logic [YW-1:0] clamp_y(input logic [YW-1:0] v);
        return (int'(v) >= VER_ACTIVE_PIXELS) ? YW'(VER_ACTIVE_PIXELS - 1) : v;
    endfunction

    always_comb begin
        setup_dx = (end_x >= start_x) ? EW'(end_x - start_x) : EW'(start_x - end_x);
        abs_dy   = (end_y >= start_y) ? EW'(end_y - start_y) : EW'(start_y - end_y);
        setup_dy = -abs_dy;
        at_end   = (cur_x == end_x) && (cur_y == end_y);
    end

    line_step #(
        .XW(XW),
        .YW(YW),
        .EW(EW)
    ) u_step (
        .err     (err),
        .dx      (dx),
        .dy      (dy),
        .sx_neg  (sx_neg),
        .sy_neg  (sy_neg),
        .cur_x   (cur_x),
        .cur_y   (cur_y),
        .next_x  (step_x),
        .next_y  (step_y),
        .next_err(step_err)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SETUP;
            SETUP:   state_next = PLOT;
            PLOT:    if (pixel_ready && at_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A pixel only advances on acceptance, so outputs hold steady through backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            start_x <= '0;
            start_y <= '0;
            end_x   <= '0;
            end_y   <= '0;
            cur_x   <= '0;
            cur_y   <= '0;
            dx      <= '0;
            dy      <= '0;
            err     <= '0;
            sx_neg  <= 1'b0;
            sy_neg  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        start_x <= clamp_x(x1);
                        start_y <= clamp_y(y1);
                        end_x   <= clamp_x(x2);
                        end_y   <= clamp_y(y2);
                    end
                end
                SETUP: begin
                    dx     <= setup_dx;
                    dy     <= setup_dy;
                    err    <= setup_dx + setup_dy;
                    sx_neg <= !(start_x < end_x);
                    sy_neg <= !(start_y < end_y);
                    cur_x  <= start_x;
                    cur_y  <= start_y;
                end
                PLOT: begin
                    if (pixel_ready && !at_end) begin
                        cur_x <= step_x;
                        cur_y <= step_y;
                        err   <= step_err;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ready       = (state == IDLE);
    assign pixel_valid = (state == PLOT);
    assign pixel_x     = cur_x;
    assign pixel_y     = cur_y;

endmodule
